// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two data-memory requesters, the arbiter and the data memory.
// The mN_lock signals exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

`ifdef DMEM_ARB_LOCK_EN
  logic          m0_lock;
  logic          m1_lock;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
`else
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata
  );
`endif
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin data-memory arbiter with 1-cycle registered read return.
// Optional bus locking is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  dmem_arbiter_if.slave bus
);

  logic          gnt0_s;
  logic          gnt1_s;
  logic          last_q;
  logic          last_d;
  logic          rvalid0_q;
  logic          rvalid0_d;
  logic          rvalid1_q;
  logic          rvalid1_d;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata0_d;
  logic [DW-1:0] rdata1_q;
  logic [DW-1:0] rdata1_d;
`ifdef DMEM_ARB_LOCK_EN
  logic          owner_vld_q;
  logic          owner_vld_d;
  logic          owner_id_q;
  logic          owner_id_d;
`endif

  // Grant decision: reset blocks everything, an owner excludes the other side, else round-robin
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (RST) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
`ifdef DMEM_ARB_LOCK_EN
    else if (owner_vld_q) begin
      gnt0_s = ~owner_id_q & bus.m0_req;
      gnt1_s =  owner_id_q & bus.m1_req;
    end
`endif
    else if (bus.m0_req && bus.m1_req) begin
      gnt0_s = last_q;
      gnt1_s = ~last_q;
    end else begin
      gnt0_s = bus.m0_req;
      gnt1_s = bus.m1_req;
    end
  end

  // Memory-side mux; idle bus is driven to zero
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    if (gnt0_s) begin
      bus.mem_we    = bus.m0_we;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
    end else if (gnt1_s) begin
      bus.mem_we    = bus.m1_we;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
    end else begin
      bus.mem_we    = 1'b0;
      bus.mem_addr  = {AW{1'b0}};
      bus.mem_wdata = {DW{1'b0}};
    end
  end

  // Next-state: round-robin history, read return capture and lock ownership
  always_comb begin
    last_d = last_q;
    if (gnt0_s) begin
      last_d = 1'b0;
    end else if (gnt1_s) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
    rvalid0_d = gnt0_s & ~bus.m0_we;
    rvalid1_d = gnt1_s & ~bus.m1_we;
    rdata0_d  = rvalid0_d ? bus.mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_rdata : rdata1_q;
`ifdef DMEM_ARB_LOCK_EN
    // A grant without lock (or no grant to the owner) releases ownership
    owner_vld_d = (gnt0_s & bus.m0_lock) | (gnt1_s & bus.m1_lock);
    owner_id_d  = owner_vld_d ? gnt1_s : owner_id_q;
`endif
  end

  // State registers; last resets to 1 so the first conflict goes to m0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q      <= 1'b1;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= {DW{1'b0}};
      rdata1_q    <= {DW{1'b0}};
`ifdef DMEM_ARB_LOCK_EN
      owner_vld_q <= 1'b0;
      owner_id_q  <= 1'b0;
`endif
    end else begin
      last_q      <= last_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef DMEM_ARB_LOCK_EN
      owner_vld_q <= owner_vld_d;
      owner_id_q  <= owner_id_d;
`endif
    end
  end

  assign bus.m0_gnt    = gnt0_s;
  assign bus.m1_gnt    = gnt1_s;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning the address width.
REQ-002 SHALL have parameter DW, default 32, meaning the data width.
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have, for each N in {0,1}, mN_req, input, 1 bit, access request from requester N (0 = core LSU, 1 = DMA/debug).
REQ-006 SHALL have mN_we, input, 1 bit, write enable (1 = write, 0 = read) of requester N.
REQ-007 SHALL have mN_addr, input, AW bits, word address of requester N.
REQ-008 SHALL have mN_wdata, input, DW bits, write data of requester N.
REQ-009 SHALL have mN_gnt, output, 1 bit, combinational grant, meaning the access is performed this cycle.
REQ-010 SHALL have mN_rvalid, output, 1 bit, registered read-data-valid pulse.
REQ-011 SHALL have mN_rdata, output, DW bits, registered read data.
REQ-012 SHALL have mem_we, output, 1 bit, write enable to the data memory.
REQ-013 SHALL have mem_addr, output, AW bits, address to the data memory.
REQ-014 SHALL have mem_wdata, output, DW bits, write data to the data memory.
REQ-015 SHALL have mem_rdata, input, DW bits, combinational read data from the data memory.
REQ-016 SHALL, only when DMEM_ARB_LOCK_EN is defined, have mN_lock, input, 1 bit, a request to hold the bus after the current access.

Function
REQ-017 SHALL grant at most one requester per cycle: m0_gnt & m1_gnt == 0 always.
REQ-018 SHALL, with only one mN_req high, grant that requester in the same cycle.
REQ-019 SHALL, with both requests high, grant the requester not granted most recently (round-robin).
REQ-020 SHALL hold a 1-bit register last, updated to N at each clock edge where mN_gnt=1, and unchanged in idle cycles.
REQ-021 SHALL drive mem_addr and mem_wdata from the granted requester; with no grant, it SHALL drive zeros.
REQ-022 SHALL set mem_we = mN_we of the granted requester; with no grant, mem_we SHALL be 0.
REQ-023 SHALL, on a granted read, capture mem_rdata into mN_rdata at that edge and pulse mN_rvalid high for exactly the next cycle (1-cycle latency).
REQ-024 SHALL NOT pulse rvalid for a granted write, and SHALL hold mN_rdata unchanged.
REQ-025 SHALL accept back-to-back grants to the same requester every cycle when the other requester is idle (full throughput).
REQ-026 SHALL leave an ungranted requester unacknowledged; it holds req, we, addr and wdata stable until granted.

Reset
REQ-027 SHALL, while RST=1 and independent of CLK, force last=1, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, and the lock owner register clear.
REQ-028 SHALL force mem_we=0 and m0_gnt=m1_gnt=0 combinationally while RST=1, so no write reaches memory during reset.
REQ-029 SHALL, on RST assertion mid-access, drop a pending rvalid and give the first post-reset conflict to m0.

Configuration
REQ-030 SHALL, with DMEM_ARB_LOCK_EN defined, let a requester granted with mN_lock=1 become owner.
REQ-031 SHALL, while an owner is set, grant only the owner; the other request waits.
REQ-032 SHALL clear ownership at the first edge where the owner's req=0 or lock=0.
REQ-033 SHALL, without DMEM_ARB_LOCK_EN, have no mN_lock ports and no owner register, with arbitration purely round-robin.

Verification
REQ-034 SHALL verify: after reset, m0 writes addr 3 data 0x0000_00AA, then reads addr 3 -> m0_gnt=1 both cycles, m0_rvalid=1 the cycle after the read, m0_rdata=0x0000_00AA.
REQ-035 SHALL verify: both requesters assert read at reset exit for 4 cycles -> grants m0,m1,m0,m1; each rvalid one cycle after its own grant.
REQ-036 SHALL verify: m1 writes addr 5 = 0x1234 while m0 is idle -> mem_we=1, mem_addr=5, mem_wdata=0x1234, no rvalid on either port.
REQ-037 SHALL verify: no requests -> mem_we=0, mem_addr=0, both gnt=0, last unchanged.
REQ-038 SHALL verify: RST pulsed asynchronously between edges during an m0 read -> m0_rvalid and m0_rdata go to 0 immediately, and the next conflict goes to m0.
REQ-039 SHALL verify, with DMEM_ARB_LOCK_EN: m1 holds lock for 3 accesses while m0 requests -> m1 granted 3 cycles, then m0 granted on the cycle after lock drops.
